// File: rtl/rp_axis_decoupler.sv
// AXI-Stream decoupler between the shell and a reconfigurable partition.
// Drains both stream paths to a packet boundary before isolating the partition.

module rp_axis_decoupler_fifo #(
    parameter int W     = 513,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    assign empty   = (count_r == {CW{1'b0}});
    assign full    = (count_r == CW'(DEPTH));
    assign rd_data = mem_r[rd_ptr_r];

    // Storage array; payload needs no reset since empty flags gate it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

module rp_axis_decoupler #(
    parameter int DATA_W        = 512,
    parameter int FIFO_DEPTH    = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic              clk100mhz_0,
    input  logic              peripheral_aresetn_0,
    input  logic              decouple_req,
    output logic              decouple_ack,
    output logic              drain_timeout,
    input  logic [DATA_W-1:0] s_txd_tdata,
    input  logic              s_txd_tlast,
    input  logic              s_txd_tvalid,
    output logic              s_txd_tready,
    output logic [DATA_W-1:0] m_txd_tdata,
    output logic              m_txd_tlast,
    output logic              m_txd_tvalid,
    input  logic              m_txd_tready,
    input  logic [DATA_W-1:0] s_rxd_tdata,
    input  logic              s_rxd_tlast,
    input  logic              s_rxd_tvalid,
    output logic              s_rxd_tready,
    output logic [DATA_W-1:0] m_rxd_tdata,
    output logic              m_rxd_tlast,
    output logic              m_rxd_tvalid,
    input  logic              m_rxd_tready
);
    localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_DECOUPLED = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic             timeout_hit_s;
    logic             drained_s;
    logic             up_r;
    logic             in_pkt_tx_r;
    logic             in_pkt_rx_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ack_r;
    logic             drain_timeout_r;

    logic             tx_open_s;
    logic             rx_open_s;
    logic             rx_sink_s;
    logic             egress_en_s;

    logic              tx_push_s, tx_pop_s, tx_empty_s, tx_full_s;
    logic              rx_push_s, rx_pop_s, rx_empty_s, rx_full_s;
    logic [DATA_W:0]   tx_rd_s;
    logic [DATA_W:0]   rx_rd_s;

    assign drained_s = !in_pkt_tx_r && !in_pkt_rx_r && tx_empty_s && rx_empty_s;

    // State register.
    always_ff @(posedge clk100mhz_0 or negedge peripheral_aresetn_0) begin
        if (!peripheral_aresetn_0) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a clean drain wins over a coincident timeout.
    always_comb begin
        next_state_s  = state_r;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (decouple_req) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!decouple_req) begin
                    next_state_s = ST_RUN;
                end else if (drained_s) begin
                    next_state_s = ST_DECOUPLED;
                end else if (cnt_r == CNT_LAST) begin
                    next_state_s  = ST_DECOUPLED;
                    timeout_hit_s = 1'b1;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DECOUPLED: begin
                if (!decouple_req) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_DECOUPLED;
                end
            end
            default: begin
                next_state_s = ST_RUN;
            end
        endcase
    end

    // Per-state gating of ingress and egress; up_r keeps tready low until reset is released.
    always_comb begin
        tx_open_s   = 1'b0;
        rx_open_s   = 1'b0;
        rx_sink_s   = 1'b0;
        egress_en_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                tx_open_s   = up_r;
                rx_open_s   = up_r;
                egress_en_s = 1'b1;
            end
            ST_DRAIN: begin
                tx_open_s   = in_pkt_tx_r;
                rx_open_s   = in_pkt_rx_r;
                egress_en_s = 1'b1;
            end
            ST_DECOUPLED: begin
                rx_sink_s = 1'b1;
            end
            default: begin
                egress_en_s = 1'b0;
            end
        endcase
    end

    assign s_txd_tready = tx_open_s && !tx_full_s;
    assign s_rxd_tready = rx_sink_s || (rx_open_s && !rx_full_s);
    assign tx_push_s    = s_txd_tvalid && tx_open_s && !tx_full_s;
    assign rx_push_s    = s_rxd_tvalid && rx_open_s && !rx_full_s;

    assign m_txd_tvalid = egress_en_s && !tx_empty_s;
    assign m_rxd_tvalid = egress_en_s && !rx_empty_s;
    assign tx_pop_s     = m_txd_tvalid && m_txd_tready;
    assign rx_pop_s     = m_rxd_tvalid && m_rxd_tready;

    assign m_txd_tdata  = m_txd_tvalid ? tx_rd_s[DATA_W-1:0] : {DATA_W{1'b0}};
    assign m_txd_tlast  = m_txd_tvalid ? tx_rd_s[DATA_W] : 1'b0;
    assign m_rxd_tdata  = m_rxd_tvalid ? rx_rd_s[DATA_W-1:0] : {DATA_W{1'b0}};
    assign m_rxd_tlast  = m_rxd_tvalid ? rx_rd_s[DATA_W] : 1'b0;

    assign decouple_ack  = ack_r;
    assign drain_timeout = drain_timeout_r;

    // Control registers: drain counter, packet tracking, ack and sticky timeout flag.
    always_ff @(posedge clk100mhz_0 or negedge peripheral_aresetn_0) begin
        if (!peripheral_aresetn_0) begin
            up_r            <= 1'b0;
            cnt_r           <= {CNT_W{1'b0}};
            in_pkt_tx_r     <= 1'b0;
            in_pkt_rx_r     <= 1'b0;
            ack_r           <= 1'b0;
            drain_timeout_r <= 1'b0;
        end else begin
            up_r  <= 1'b1;
            ack_r <= (next_state_s == ST_DECOUPLED);
            if ((state_r == ST_DRAIN) && (next_state_s == ST_DRAIN)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            if (timeout_hit_s) begin
                in_pkt_tx_r <= 1'b0;
                in_pkt_rx_r <= 1'b0;
            end else begin
                if (tx_push_s) begin
                    in_pkt_tx_r <= !s_txd_tlast;
                end
                if (rx_push_s) begin
                    in_pkt_rx_r <= !s_rxd_tlast;
                end
            end
            if (timeout_hit_s) begin
                drain_timeout_r <= 1'b1;
            end else if ((state_r == ST_DECOUPLED) && !decouple_req) begin
                drain_timeout_r <= 1'b0;
            end else begin
                drain_timeout_r <= drain_timeout_r;
            end
        end
    end

    rp_axis_decoupler_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_txd_fifo (
        .clk     (clk100mhz_0),
        .rst_n   (peripheral_aresetn_0),
        .flush   (timeout_hit_s),
        .push    (tx_push_s),
        .wr_data ({s_txd_tlast, s_txd_tdata}),
        .pop     (tx_pop_s),
        .rd_data (tx_rd_s),
        .empty   (tx_empty_s),
        .full    (tx_full_s)
    );

    rp_axis_decoupler_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_rxd_fifo (
        .clk     (clk100mhz_0),
        .rst_n   (peripheral_aresetn_0),
        .flush   (timeout_hit_s),
        .push    (rx_push_s),
        .wr_data ({s_rxd_tlast, s_rxd_tdata}),
        .pop     (rx_pop_s),
        .rd_data (rx_rd_s),
        .empty   (rx_empty_s),
        .full    (rx_full_s)
    );
endmodule

// File: tb/tb_rp_axis_decoupler.sv
// Self-checking bench for rp_axis_decoupler: queue-based reference model plus
// directed scenarios and randomized traffic with random decouple requests.

module tb_rp_axis_decoupler;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int TO    = 8;

    typedef logic [DW:0] beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic          ack, dto;
    logic [DW-1:0] s_txd_tdata, m_txd_tdata, s_rxd_tdata, m_rxd_tdata;
    logic          s_txd_tlast, s_txd_tvalid, s_txd_tready;
    logic          m_txd_tlast, m_txd_tvalid, m_txd_tready;
    logic          s_rxd_tlast, s_rxd_tvalid, s_rxd_tready;
    logic          m_rxd_tlast, m_rxd_tvalid, m_rxd_tready;

    always #5 clk = ~clk;

    rp_axis_decoupler #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DRAIN_TIMEOUT(TO)) dut (
        .clk100mhz_0          (clk),
        .peripheral_aresetn_0 (rst_n),
        .decouple_req         (req),
        .decouple_ack         (ack),
        .drain_timeout        (dto),
        .s_txd_tdata          (s_txd_tdata),
        .s_txd_tlast          (s_txd_tlast),
        .s_txd_tvalid         (s_txd_tvalid),
        .s_txd_tready         (s_txd_tready),
        .m_txd_tdata          (m_txd_tdata),
        .m_txd_tlast          (m_txd_tlast),
        .m_txd_tvalid         (m_txd_tvalid),
        .m_txd_tready         (m_txd_tready),
        .s_rxd_tdata          (s_rxd_tdata),
        .s_rxd_tlast          (s_rxd_tlast),
        .s_rxd_tvalid         (s_rxd_tvalid),
        .s_rxd_tready         (s_rxd_tready),
        .m_rxd_tdata          (m_rxd_tdata),
        .m_rxd_tlast          (m_rxd_tlast),
        .m_rxd_tvalid         (m_rxd_tvalid),
        .m_rxd_tready         (m_rxd_tready)
    );

    // Reference model: queues per path, mode 0=RUN 1=DRAIN 2=DECOUPLED.
    beat_t q_tx[$];
    beat_t q_rx[$];
    bit    in_tx, in_rx, up, mto;
    int    mst, mcnt;
    bit    e_stt, e_srt, e_mtv, e_mrv, e_ack, e_to;
    beat_t e_mtb, e_mrb;
    bit    acc_tx, acc_rx;
    int    checks = 0;
    int    errors = 0;

    function automatic logic [DW-1:0] rnd();
        return {$urandom(), $urandom()};
    endfunction

    function automatic void compute_exp();
        e_stt = up && (mst != 2) && (mst == 0 || in_tx) && (q_tx.size() < DEPTH);
        e_srt = up && ((mst == 2) || ((mst == 0 || in_rx) && (q_rx.size() < DEPTH)));
        e_mtv = (mst != 2) && (q_tx.size() > 0);
        e_mrv = (mst != 2) && (q_rx.size() > 0);
        e_mtb = e_mtv ? q_tx[0] : '0;
        e_mrb = e_mrv ? q_rx[0] : '0;
        e_ack = (mst == 2);
        e_to  = mto;
    endfunction

    task automatic advance();
        bit flush, txp, rxp, txo, rxo;
        compute_exp();
        txp    = s_txd_tvalid && e_stt;
        rxp    = s_rxd_tvalid && e_srt && (mst != 2);
        txo    = e_mtv && m_txd_tready;
        rxo    = e_mrv && m_rxd_tready;
        acc_tx = txp;
        acc_rx = s_rxd_tvalid && e_srt;
        @(posedge clk);
        flush = 1'b0;
        case (mst)
            0: if (req) begin mst = 1; mcnt = 0; end
            1: begin
                if (!req) begin
                    mst = 0; mcnt = 0;
                end else if (!in_tx && !in_rx && q_tx.size() == 0 && q_rx.size() == 0) begin
                    mst = 2; mcnt = 0;
                end else if (mcnt == TO - 1) begin
                    mst = 2; mcnt = 0; flush = 1'b1; mto = 1'b1;
                end else begin
                    mcnt++;
                end
            end
            default: if (!req) begin mst = 0; mto = 1'b0; end
        endcase
        if (txo) void'(q_tx.pop_front());
        if (rxo) void'(q_rx.pop_front());
        if (txp) begin q_tx.push_back({s_txd_tlast, s_txd_tdata}); in_tx = !s_txd_tlast; end
        if (rxp) begin q_rx.push_back({s_rxd_tlast, s_rxd_tdata}); in_rx = !s_rxd_tlast; end
        if (flush) begin q_tx.delete(); q_rx.delete(); in_tx = 1'b0; in_rx = 1'b0; end
        up = 1'b1;
        @(negedge clk);
        compute_exp();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = 1'b0;
        s_txd_tvalid = 1'b0; s_txd_tlast = 1'b0; s_txd_tdata = '0; m_txd_tready = 1'b0;
        s_rxd_tvalid = 1'b0; s_rxd_tlast = 1'b0; s_rxd_tdata = '0; m_rxd_tready = 1'b0;
        q_tx.delete(); q_rx.delete();
        in_tx = 1'b0; in_rx = 1'b0; up = 1'b0; mto = 1'b0; mst = 0; mcnt = 0;
        acc_tx = 1'b0; acc_rx = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compute_exp();
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        rst_n = 1'b0;
        req = 1'b0;
        s_txd_tvalid = 1'b1; s_rxd_tvalid = 1'b1; m_txd_tready = 1'b1; m_rxd_tready = 1'b1;
        @(negedge clk);
        outs = {s_txd_tready, m_txd_tvalid, m_txd_tlast, |m_txd_tdata, s_rxd_tready,
                m_rxd_tvalid, m_rxd_tlast, |m_rxd_tdata, ack, dto};
        checks++;
        if (outs !== 10'b0) begin
            errors++; $display("FAIL reset_outputs got %b want 0000000000", outs);
        end
        apply_reset();
        advance();
        checks++;
        if ({s_txd_tready, s_rxd_tready, m_txd_tvalid, m_rxd_tvalid, ack, dto} !== 6'b110000) begin
            errors++;
            $display("FAIL post_reset got %b want 110000",
                     {s_txd_tready, s_rxd_tready, m_txd_tvalid, m_rxd_tvalid, ack, dto});
        end
    endtask

    task automatic test_passthrough();
        logic [DW-1:0] d [4];
        int i = 0;
        int seen = 0;
        apply_reset();
        m_txd_tready = 1'b1;
        for (int k = 0; k < 4; k++) d[k] = rnd();
        for (int c = 0; c < 12; c++) begin
            s_txd_tvalid = (i < 4);
            s_txd_tdata  = (i < 4) ? d[i] : '0;
            s_txd_tlast  = (i == 3);
            compute_exp();
            checks++;
            if (m_txd_tvalid !== e_mtv || s_txd_tready !== e_stt) begin
                errors++;
                $display("FAIL pass_handshake cyc %0d got v=%b r=%b want v=%b r=%b",
                         c, m_txd_tvalid, s_txd_tready, e_mtv, e_stt);
            end
            if (m_txd_tvalid === 1'b1 && seen < 4) begin
                checks++;
                if ({m_txd_tlast, m_txd_tdata} !== {seen == 3, d[seen]}) begin
                    errors++;
                    $display("FAIL pass_beat %0d got %h want %h", seen,
                             {m_txd_tlast, m_txd_tdata}, {seen == 3, d[seen]});
                end
                seen++;
            end
            advance();
            if (acc_tx) i++;
        end
        checks++;
        if (seen != 4) begin
            errors++; $display("FAIL pass_count got %0d want 4", seen);
        end
    endtask

    task automatic test_full();
        beat_t sent[$];
        beat_t cur;
        int popped = 0;
        apply_reset();
        cur = {1'b1, rnd()};
        s_rxd_tvalid = 1'b1;
        {s_rxd_tlast, s_rxd_tdata} = cur;
        for (int c = 0; c < 60 && sent.size() < DEPTH; c++) begin
            checks++;
            if (s_rxd_tready !== e_srt) begin
                errors++; $display("FAIL fill_ready got %b want %b", s_rxd_tready, e_srt);
            end
            advance();
            if (acc_rx) begin
                sent.push_back(cur); cur = {1'b1, rnd()}; {s_rxd_tlast, s_rxd_tdata} = cur;
            end
        end
        checks++;
        if (s_rxd_tready !== 1'b0) begin
            errors++; $display("FAIL full_ready got %b want 0", s_rxd_tready);
        end
        m_rxd_tready = 1'b1;
        checks++;
        if ({m_rxd_tlast, m_rxd_tdata} !== sent[0] || m_rxd_tvalid !== 1'b1) begin
            errors++; $display("FAIL full_head got %h want %h", {m_rxd_tlast, m_rxd_tdata}, sent[0]);
        end
        advance();
        void'(sent.pop_front()); popped++;
        m_rxd_tready = 1'b0;
        advance();
        if (acc_rx) sent.push_back(cur);
        s_rxd_tvalid = 1'b0;
        checks++;
        if (s_rxd_tready !== 1'b0 || sent.size() != DEPTH) begin
            errors++;
            $display("FAIL refill got ready=%b held=%0d want ready=0 held=%0d",
                     s_rxd_tready, sent.size(), DEPTH);
        end
        m_rxd_tready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (m_rxd_tvalid === 1'b1) begin
                checks++;
                if (sent.size() == 0 || {m_rxd_tlast, m_rxd_tdata} !== sent[0]) begin
                    errors++; $display("FAIL full_drain beat %0d got %h", popped, {m_rxd_tlast, m_rxd_tdata});
                end
                if (sent.size() != 0) void'(sent.pop_front());
                popped++;
            end
            advance();
        end
        checks++;
        if (popped != DEPTH + 1) begin
            errors++; $display("FAIL full_total got %0d want %0d", popped, DEPTH + 1);
        end
    endtask

    task automatic test_clean_drain();
        logic [DW-1:0] d [5];
        logic [DW-1:0] nxt;
        int i = 0;
        apply_reset();
        m_txd_tready = 1'b1;
        for (int k = 0; k < 5; k++) d[k] = rnd();
        nxt = rnd();
        for (int c = 0; c < 40; c++) begin
            if (ack === 1'b1) break;
            if (i >= 2) req = 1'b1;
            s_txd_tvalid = 1'b1;
            s_txd_tdata  = (i < 5) ? d[i] : nxt;
            s_txd_tlast  = (i == 4);
            compute_exp();
            checks++;
            if ({s_txd_tready, m_txd_tvalid, ack} !== {e_stt, e_mtv, e_ack} ||
                (e_mtv && {m_txd_tlast, m_txd_tdata} !== e_mtb)) begin
                errors++;
                $display("FAIL drain_cycle %0d got r=%b v=%b a=%b want r=%b v=%b a=%b",
                         c, s_txd_tready, m_txd_tvalid, ack, e_stt, e_mtv, e_ack);
            end
            advance();
            if (i >= 5) begin
                checks++;
                if (acc_tx) begin errors++; $display("FAIL drain_stall got accepted want stalled"); end
            end else if (acc_tx) begin
                i++;
            end
        end
        checks++;
        if (i != 5 || ack !== 1'b1 || dto !== 1'b0) begin
            errors++;
            $display("FAIL clean_drain got beats=%0d ack=%b to=%b want 5 1 0", i, ack, dto);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        apply_reset();
        m_txd_tready = 1'b0;
        for (int c = 0; c < 10 && n < 2; c++) begin
            s_txd_tvalid = 1'b1; s_txd_tlast = 1'b0; s_txd_tdata = rnd();
            advance();
            if (acc_tx) n++;
        end
        s_txd_tvalid = 1'b0;
        req = 1'b1;
        advance();
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            advance();
            if (ack === 1'b1) begin n = k; break; end
        end
        checks++;
        if (n != TO || dto !== 1'b1 || e_to !== 1'b1) begin
            errors++; $display("FAIL timeout got cycles=%0d to=%b want %0d 1", n, dto, TO);
        end
        req = 1'b0;
        m_txd_tready = 1'b1;
        advance();
        checks++;
        if ({ack, dto, m_txd_tvalid, s_txd_tready} !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_recouple got %b want 0001", {ack, dto, m_txd_tvalid, s_txd_tready});
        end
        req = 1'b1;
        advance();
        advance();
        checks++;
        if (ack !== 1'b1 || dto !== 1'b0) begin
            errors++; $display("FAIL redrain_clean got ack=%b to=%b want 1 0", ack, dto);
        end
    endtask

    task automatic test_isolation();
        beat_t tb, rb;
        int tx_seen = 0;
        int rx_seen = 0;
        apply_reset();
        m_txd_tready = 1'b1; m_rxd_tready = 1'b1;
        req = 1'b1;
        advance(); advance();
        tb = {1'b1, rnd()};
        {s_txd_tlast, s_txd_tdata} = tb;
        s_txd_tvalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            s_rxd_tvalid = $urandom_range(0, 1) == 1;
            s_rxd_tlast  = $urandom_range(0, 1) == 1;
            s_rxd_tdata  = rnd();
            #1;
            checks++;
            if ({m_rxd_tvalid, s_rxd_tready, s_txd_tready, m_txd_tvalid, m_txd_tlast, |m_txd_tdata, ack}
                !== 7'b0100001) begin
                errors++;
                $display("FAIL isolate cyc %0d got %b want 0100001", c,
                         {m_rxd_tvalid, s_rxd_tready, s_txd_tready, m_txd_tvalid, m_txd_tlast, |m_txd_tdata, ack});
            end
            advance();
        end
        s_rxd_tvalid = 1'b0;
        req = 1'b0;
        advance();
        checks++;
        if (ack !== 1'b0 || dto !== 1'b0) begin
            errors++; $display("FAIL recouple got ack=%b to=%b want 0 0", ack, dto);
        end
        rb = {1'b1, rnd()};
        {s_rxd_tlast, s_rxd_tdata} = rb;
        s_rxd_tvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (m_txd_tvalid === 1'b1) begin
                tx_seen++; checks++;
                if ({m_txd_tlast, m_txd_tdata} !== tb) begin
                    errors++; $display("FAIL recouple_tx got %h want %h", {m_txd_tlast, m_txd_tdata}, tb);
                end
            end
            if (m_rxd_tvalid === 1'b1) begin
                rx_seen++; checks++;
                if ({m_rxd_tlast, m_rxd_tdata} !== rb) begin
                    errors++; $display("FAIL recouple_rx got %h want %h", {m_rxd_tlast, m_rxd_tdata}, rb);
                end
            end
            advance();
            if (acc_tx) s_txd_tvalid = 1'b0;
            if (acc_rx) s_rxd_tvalid = 1'b0;
        end
        checks++;
        if (tx_seen != 1 || rx_seen != 1) begin
            errors++; $display("FAIL recouple_count got tx=%0d rx=%0d want 1 1", tx_seen, rx_seen);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 700; c++) begin
            if (!s_txd_tvalid || acc_tx) begin
                s_txd_tvalid = $urandom_range(0, 3) != 0;
                s_txd_tlast  = $urandom_range(0, 3) == 0;
                s_txd_tdata  = rnd();
            end
            if (!s_rxd_tvalid || acc_rx) begin
                s_rxd_tvalid = $urandom_range(0, 3) != 0;
                s_rxd_tlast  = $urandom_range(0, 3) == 0;
                s_rxd_tdata  = rnd();
            end
            m_txd_tready = $urandom_range(0, 3) != 0;
            m_rxd_tready = $urandom_range(0, 4) != 0;
            if (c >= 250 && $urandom_range(0, 15) == 0) req = !req;
            compute_exp();
            checks++;
            if ({s_txd_tready, s_rxd_tready, m_txd_tvalid, m_rxd_tvalid, ack, dto} !==
                {e_stt, e_srt, e_mtv, e_mrv, e_ack, e_to}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d got %b want %b", c,
                         {s_txd_tready, s_rxd_tready, m_txd_tvalid, m_rxd_tvalid, ack, dto},
                         {e_stt, e_srt, e_mtv, e_mrv, e_ack, e_to});
            end
            checks++;
            if ({m_txd_tlast, m_txd_tdata} !== e_mtb || {m_rxd_tlast, m_rxd_tdata} !== e_mrb) begin
                errors++;
                $display("FAIL rand_data cyc %0d got tx=%h rx=%h want tx=%h rx=%h", c,
                         {m_txd_tlast, m_txd_tdata}, {m_rxd_tlast, m_rxd_tdata}, e_mtb, e_mrb);
            end
            advance();
        end
        req = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        logic [9:0] outs;
        apply_reset();
        m_txd_tready = 1'b0; m_rxd_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            s_txd_tvalid = 1'b1; s_txd_tlast = 1'b0; s_txd_tdata = rnd();
            s_rxd_tvalid = 1'b1; s_rxd_tlast = 1'b0; s_rxd_tdata = rnd();
            advance();
        end
        req = 1'b1;
        advance(); advance();
        #2 rst_n = 1'b0;
        #1;
        outs = {s_txd_tready, m_txd_tvalid, m_txd_tlast, |m_txd_tdata, s_rxd_tready,
                m_rxd_tvalid, m_rxd_tlast, |m_rxd_tdata, ack, dto};
        checks++;
        if (outs !== 10'b0) begin
            errors++; $display("FAIL mid_reset_outputs got %b want 0000000000", outs);
        end
        apply_reset();
        advance();
        checks++;
        if ({ack, m_txd_tvalid, m_rxd_tvalid, s_txd_tready} !== 4'b0001) begin
            errors++;
            $display("FAIL mid_reset_run got %b want 0001", {ack, m_txd_tvalid, m_rxd_tvalid, s_txd_tready});
        end
        req = 1'b1;
        advance(); advance();
        checks++;
        if (ack !== 1'b1 || dto !== 1'b0) begin
            errors++; $display("FAIL mid_reset_redrain got ack=%b to=%b want 1 0", ack, dto);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_full();
        test_clean_drain();
        test_timeout();
        test_isolation();
        test_random();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
